// File: rtl/dsa_pkg.sv
// Shared types and constants for the DSA coordinate generator.
//   coord_state_t : frame sequencing states
//   Q16_ONE       : 1.0 in Q16.16
//   FRAC_MAX      : largest Q0.16 fraction, used when clamping to the last pixel pair
package dsa_pkg;

    localparam logic [31:0] Q16_ONE  = 32'h0001_0000;
    localparam logic [15:0] FRAC_MAX = 16'hFFFF;

    localparam int unsigned COORD_W = 16;
    localparam int unsigned FRAC_W  = $clog2(Q16_ONE);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        ADVANCE,
        FINISH
    } coord_state_t;

endpackage

// File: rtl/dsa_axis_stepper.sv
// One axis of the source-coordinate walk: Q16.16 accumulator with load/clear/add,
// and a clamp that keeps the +1 interpolation neighbour inside the source image.
//   clk, rst     : clock, synchronous active-high reset
//   load         : latch dim_in/step_in and zero the accumulator (frame start)
//   clear        : zero the accumulator (row wrap on x)
//   add          : accumulator += latched step
//   coord_int    : registered integer source coordinate (clamped)
//   frac         : registered Q0.16 fraction (FRAC_MAX when clamped)
// ACC_WIDTH must be at least 32 so the integer field sits at [31:16].
module dsa_axis_stepper
    import dsa_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [COORD_W-1:0]  dim_in,
    input  logic [31:0]         step_in,
    input  logic                clear,
    input  logic                add,
    output logic [COORD_W-1:0]  coord_int,
    output logic [FRAC_W-1:0]   frac
);

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [COORD_W-1:0]   dim_q;
    logic [COORD_W-1:0]   dim_sel;
    logic [31:0]          step_q;
    logic [COORD_W-1:0]   int_d;
    logic [FRAC_W-1:0]    frac_d;

    // Next accumulator and its clamped coordinate; on load the incoming dimension
    // is used so the first pixel's coordinate is correct in the same cycle.
    always_comb begin
        acc_d   = acc_q;
        dim_sel = dim_q;
        if (load) begin
            acc_d   = '0;
            dim_sel = dim_in;
        end else if (clear) begin
            acc_d = '0;
        end else if (add) begin
            acc_d = acc_q + ACC_WIDTH'(step_q);
        end
        int_d  = acc_d[FRAC_W +: COORD_W];
        frac_d = acc_d[FRAC_W-1:0];
        if (int_d >= dim_sel - COORD_W'(1)) begin
            int_d  = dim_sel - COORD_W'(2);
            frac_d = FRAC_MAX;
        end
    end

    // Coordinates only move on load/clear/add so they stay stable while a request is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            dim_q     <= '0;
            step_q    <= '0;
            coord_int <= '0;
            frac      <= '0;
        end else begin
            acc_q <= acc_d;
            if (load) begin
                dim_q  <= dim_in;
                step_q <= step_in;
            end
            if (load || clear || add) begin
                coord_int <= int_d;
                frac      <= frac_d;
            end
        end
    end

endmodule

// File: rtl/dsa_coord_gen.sv
// Destination-driven source-coordinate generator for a scaler. Walks the
// destination raster and issues one fetch request per pixel, handshaking on the
// fetch stage's busy flag.
//   clk, rst                : clock, synchronous active-high reset
//   start                   : begin a frame (ignored while busy)
//   src_width/src_height    : source dimensions (>= 2)
//   dst_width/dst_height    : destination dimensions (0 => empty frame)
//   step_x/step_y           : Q16.16 source increment per destination pixel
//   fetch_busy              : fetch stage busy flag
//   req_valid               : one-cycle fetch request
//   src_x_int/src_y_int     : clamped top-left source coordinate
//   frac_x/frac_y           : Q0.16 fractions
//   dst_x/dst_y             : destination pixel of the current request
//   busy                    : frame in progress
//   done                    : one-cycle end-of-frame pulse
module dsa_coord_gen
    import dsa_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [15:0]  src_width,
    input  logic [15:0]  src_height,
    input  logic [15:0]  dst_width,
    input  logic [15:0]  dst_height,
    input  logic [31:0]  step_x,
    input  logic [31:0]  step_y,
    input  logic         fetch_busy,
    output logic         req_valid,
    output logic [15:0]  src_x_int,
    output logic [15:0]  src_y_int,
    output logic [15:0]  frac_x,
    output logic [15:0]  frac_y,
    output logic [15:0]  dst_x,
    output logic [15:0]  dst_y,
    output logic         busy,
    output logic         done
);

    coord_state_t state;
    logic [15:0]  dst_w_q;
    logic [15:0]  dst_h_q;
    logic         load;
    logic         row_end;
    logic         last_row;
    logic         x_add;
    logic         x_clear;
    logic         y_add;

    assign row_end  = (dst_x == dst_w_q - 16'd1);
    assign last_row = (dst_y == dst_h_q - 16'd1);

    // Accumulator controls, derived from the current state.
    always_comb begin
        load    = (state == IDLE) && start;
        x_add   = 1'b0;
        x_clear = 1'b0;
        y_add   = 1'b0;
        if (state == ADVANCE) begin
            if (!row_end) begin
                x_add = 1'b1;
            end else if (!last_row) begin
                x_clear = 1'b1;
                y_add   = 1'b1;
            end
        end
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dst_x     <= '0;
            dst_y     <= '0;
            dst_w_q   <= '0;
            dst_h_q   <= '0;
        end else begin
            req_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dst_w_q <= dst_width;
                        dst_h_q <= dst_height;
                        dst_x   <= '0;
                        dst_y   <= '0;
                        busy    <= 1'b1;
                        state   <= (dst_width == 16'd0 || dst_height == 16'd0) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    if (!fetch_busy) begin
                        req_valid <= 1'b1;
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (fetch_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!fetch_busy) state <= ADVANCE;
                end
                ADVANCE: begin
                    if (!row_end) begin
                        dst_x <= dst_x + 16'd1;
                        state <= ISSUE;
                    end else if (!last_row) begin
                        dst_x <= '0;
                        dst_y <= dst_y + 16'd1;
                        state <= ISSUE;
                    end else begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    dsa_axis_stepper #(.ACC_WIDTH(ACC_WIDTH)) u_step_x (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .dim_in    (src_width),
        .step_in   (step_x),
        .clear     (x_clear),
        .add       (x_add),
        .coord_int (src_x_int),
        .frac      (frac_x)
    );

    dsa_axis_stepper #(.ACC_WIDTH(ACC_WIDTH)) u_step_y (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .dim_in    (src_height),
        .step_in   (step_y),
        .clear     (1'b0),
        .add       (y_add),
        .coord_int (src_y_int),
        .frac      (frac_y)
    );

endmodule

// File: tb/tb_dsa_coord_gen.sv
// Directed bench for dsa_coord_gen with a 6-busy-cycle fetch model.
module tb_dsa_coord_gen;

    typedef struct packed {
        logic [15:0] sx;
        logic [15:0] sy;
        logic [15:0] fx;
        logic [15:0] fy;
        logic [15:0] dx;
        logic [15:0] dy;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_width, src_height, dst_width, dst_height;
    logic [31:0] step_x, step_y;
    logic        fetch_busy;
    logic        req_valid;
    logic [15:0] src_x_int, src_y_int, frac_x, frac_y, dst_x, dst_y;
    logic        busy, done;

    logic model_busy = 1'b0;
    logic hold_busy  = 1'b0;
    assign fetch_busy = model_busy | hold_busy;

    int   cyc      = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    req_t req_q[$];

    dsa_coord_gen #(.ACC_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_width  (src_width),
        .src_height (src_height),
        .dst_width  (dst_width),
        .dst_height (dst_height),
        .step_x     (step_x),
        .step_y     (step_y),
        .fetch_busy (fetch_busy),
        .req_valid  (req_valid),
        .src_x_int  (src_x_int),
        .src_y_int  (src_y_int),
        .frac_x     (frac_x),
        .frac_y     (frac_y),
        .dst_x      (dst_x),
        .dst_y      (dst_y),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal fetch stage: capture each request, then stay busy for 6 cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (req_valid === 1'b1) begin
                req_q.push_back({src_x_int, src_y_int, frac_x, frac_y, dst_x, dst_y});
                model_busy = 1'b1;
                repeat (6) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic req_t cur_outs();
        return {src_x_int, src_y_int, frac_x, frac_y, dst_x, dst_y};
    endfunction

    // Top-left aligned mapping with clamp to (dim-2, FFFF).
    function automatic req_t exp_req(input int dx, input int dy, input logic [31:0] st,
                                     input logic [15:0] sw, input logic [15:0] sh);
        req_t r;
        logic [31:0] ax, ay;
        ax = st * 32'(dx);
        ay = st * 32'(dy);
        r.sx = ax[31:16];
        r.fx = ax[15:0];
        r.sy = ay[31:16];
        r.fy = ay[15:0];
        if (r.sx >= sw - 16'd1) begin
            r.sx = sw - 16'd2;
            r.fx = 16'hFFFF;
        end
        if (r.sy >= sh - 16'd1) begin
            r.sy = sh - 16'd2;
            r.fy = 16'hFFFF;
        end
        r.dx = 16'(dx);
        r.dy = 16'(dy);
        return r;
    endfunction

    task automatic start_frame(input logic [15:0] sw, input logic [15:0] sh,
                               input logic [15:0] dw, input logic [15:0] dh,
                               input logic [31:0] st);
        src_width  = sw;
        src_height = sh;
        dst_width  = dw;
        dst_height = dh;
        step_x     = st;
        step_y     = st;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 96'(done_cnt != d0), 96'(1));
    endtask

    task automatic wait_reqs(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (req_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 96'(req_q.size() >= target), 96'(1));
    endtask

    task automatic check_frame(input string tag, input int base, input int dw, input int dh,
                               input logic [31:0] st, input logic [15:0] sw, input logic [15:0] sh);
        req_t got;
        check({tag, "_count"}, 96'(req_q.size() - base), 96'(dw * dh));
        for (int i = 0; i < dw * dh; i++) begin
            got = (base + i < req_q.size()) ? req_q[base + i] : '0;
            check($sformatf("%s_req%0d", tag, i), 96'(got), 96'(exp_req(i % dw, i / dw, st, sw, sh)));
        end
    endtask

    initial begin
        int base;
        int d0;
        int start_cyc;
        int rv_seen;
        rst = 1'b1;
        start = 1'b0;
        src_width = '0; src_height = '0; dst_width = '0; dst_height = '0;
        step_x = '0; step_y = '0;
        tick(3);
        rst = 1'b0;
        check("rst_ctrl", 96'({req_valid, busy, done}), 96'(0));
        check("rst_coords", 96'(cur_outs()), 96'(0));

        // Upscale 4x4 -> 8x8, half-pixel step.
        base = req_q.size();
        d0 = done_cnt;
        start_frame(16'd4, 16'd4, 16'd8, 16'd8, 32'h8000);
        check("up_busy", 96'(busy), 96'(1));
        wait_done("up_done_seen", 2000);
        tick(3);
        check("up_req0", 96'(req_q[base]), {16'd0, 16'd0, 16'h0000, 16'd0, 16'd0, 16'd0});
        check("up_req1", 96'(req_q[base + 1]), {16'd0, 16'd0, 16'h8000, 16'd0, 16'd1, 16'd0});
        check("up_req6", 96'(req_q[base + 6]), {16'd2, 16'd0, 16'hFFFF, 16'd0, 16'd6, 16'd0});
        check_frame("up", base, 8, 8, 32'h8000, 16'd4, 16'd4);
        check("up_done_once", 96'(done_cnt - d0), 96'(1));
        check("up_idle", 96'(busy), 96'(0));

        // Downscale 8x8 -> 4x4, step 2.0.
        base = req_q.size();
        start_frame(16'd8, 16'd8, 16'd4, 16'd4, 32'h20000);
        wait_done("dn_done_seen", 1000);
        check("dn_req5", 96'(req_q[base + 5]), {16'd2, 16'd2, 16'd0, 16'd0, 16'd1, 16'd1});
        check("dn_req15", 96'(req_q[base + 15]), {16'd6, 16'd6, 16'd0, 16'd0, 16'd3, 16'd3});
        check_frame("dn", base, 4, 4, 32'h20000, 16'd8, 16'd8);

        // Empty frame: done two cycles after start, no requests.
        base = req_q.size();
        d0 = done_cnt;
        start_cyc = cyc;
        start_frame(16'd4, 16'd4, 16'd0, 16'd5, 32'h10000);
        tick(5);
        check("empty_done_cnt", 96'(done_cnt - d0), 96'(1));
        check("empty_done_lat", 96'(done_cyc - start_cyc), 96'(2));
        check("empty_no_req", 96'(req_q.size() - base), 96'(0));

        // Fetch stage busy for 10 cycles at frame start.
        base = req_q.size();
        hold_busy = 1'b1;
        rv_seen = 0;
        start_frame(16'd4, 16'd4, 16'd2, 16'd1, 32'h10000);
        for (int i = 0; i < 9; i++) begin
            if (req_valid === 1'b1) rv_seen++;
            tick();
        end
        if (req_valid === 1'b1) rv_seen++;
        check("hold_no_req", 96'(rv_seen), 96'(0));
        check("hold_busy_out", 96'(busy), 96'(1));
        hold_busy = 1'b0;
        tick();
        check("hold_req_rise", 96'(req_valid), 96'(1));
        tick();
        check("hold_req_pulse", 96'(req_valid), 96'(0));
        wait_done("hold_done_seen", 500);
        check_frame("hold", base, 2, 1, 32'h10000, 16'd4, 16'd4);

        // Reset during WAIT_DONE of pixel 5, then restart.
        base = req_q.size();
        start_frame(16'd4, 16'd4, 16'd4, 16'd4, 32'h10000);
        wait_reqs("rst_reach_px5", base + 6, 500);
        check("rst_px5_dst", 96'({req_q[base + 5].dx, req_q[base + 5].dy}), 96'({16'd1, 16'd1}));
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ctrl", 96'({req_valid, busy, done}), 96'(0));
        check("midrst_coords", 96'(cur_outs()), 96'(0));
        tick(10);
        check("midrst_no_done", 96'(done_cnt - d0), 96'(0));
        base = req_q.size();
        start_frame(16'd4, 16'd4, 16'd4, 16'd4, 32'h10000);
        wait_reqs("restart_first", base + 1, 200);
        check("restart_req0", 96'(req_q[base]), 96'(0));
        wait_done("restart_done_seen", 1000);
        check_frame("restart", base, 4, 4, 32'h10000, 16'd4, 16'd4);

        // Start pulsed mid-frame with different parameters must be ignored.
        base = req_q.size();
        d0 = done_cnt;
        start_frame(16'd8, 16'd8, 16'd4, 16'd4, 32'h20000);
        wait_reqs("ign_reach", base + 3, 500);
        start_frame(16'd4, 16'd4, 16'd2, 16'd2, 32'h8000);
        wait_done("ign_done_seen", 1000);
        tick(3);
        check_frame("ign", base, 4, 4, 32'h20000, 16'd8, 16'd8);
        check("ign_done_once", 96'(done_cnt - d0), 96'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsa_coord_gen.md
DSA_COORD_GEN -- requirements
Module: dsa_coord_gen

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32, meaning the Q16.16 source-coordinate accumulator width.
REQ-002 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start  in  1  one-cycle request to begin a frame; ignored unless idle.
REQ-005 SHALL have ports src_width, src_height  in  16 each  source image dimensions, minimum 2.
REQ-006 SHALL have ports dst_width, dst_height  in  16 each  destination image dimensions.
REQ-007 SHALL have ports step_x, step_y  in  32 each  Q16.16 source increment per destination pixel.
REQ-008 SHALL have port fetch_busy  in  1  busy flag of the downstream pixel-fetch stage.
REQ-009 SHALL have port req_valid  out  1  one-cycle request to the fetch stage.
REQ-010 SHALL have ports src_x_int, src_y_int, frac_x, frac_y  out  16 each  top-left source integer coordinate and Q0.16 fractions.
REQ-011 SHALL have ports dst_x, dst_y  out  16 each  destination pixel that the current request belongs to.
REQ-012 SHALL have ports busy, done  out  1 each  busy means the frame is in progress; done is a one-cycle end-of-frame pulse.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT_ACK, WAIT_DONE, ADVANCE, FINISH.
REQ-014 In IDLE, start SHALL latch all dimension and step inputs, clear acc_x, acc_y, dst_x and dst_y, and go to ISSUE; if dst_width or dst_height is 0, it SHALL go to FINISH instead.
REQ-015 In ISSUE, req_valid SHALL be 1 only while fetch_busy=0, and that same cycle SHALL move to WAIT_ACK; while fetch_busy=1 it SHALL hold in ISSUE with req_valid=0.
REQ-016 WAIT_ACK SHALL hold until fetch_busy=1, then go to WAIT_DONE.
REQ-017 WAIT_DONE SHALL hold until fetch_busy=0, then go to ADVANCE.
REQ-018 ADVANCE, when not at the end of a row, SHALL increment dst_x, add step_x to acc_x, and go to ISSUE.
REQ-019 ADVANCE, when dst_x = dst_width-1 and the row is not the last, SHALL clear dst_x and acc_x, increment dst_y, add step_y to acc_y, and go to ISSUE.
REQ-020 ADVANCE, at the last pixel (dst_x = dst_width-1 and dst_y = dst_height-1), SHALL go to FINISH.
REQ-021 FINISH SHALL assert done for exactly one cycle and then go to IDLE.
REQ-022 Coordinate mapping SHALL be top-left aligned: src_x_int = acc_x[31:16] and frac_x = acc_x[15:0]; the y axis SHALL be identical.
REQ-023 Boundary clamp: if acc_x[31:16] is at least src_width-1, the block SHALL output src_x_int = src_width-2 and frac_x = 16'hFFFF, so the +1 neighbour stays in bounds; the y axis SHALL be identical.
REQ-024 Coordinate outputs, dst_x and dst_y SHALL be registered and SHALL stay stable from ISSUE entry through WAIT_DONE exit.
REQ-025 Accumulators SHALL wrap modulo 2^ACC_WIDTH; callers SHALL guarantee step multiplied by dst_dim is less than 2^32.
REQ-026 busy SHALL be 1 in every state except IDLE, including FINISH.
REQ-027 start while busy=1 SHALL have no effect.

Reset
REQ-028 rst SHALL force IDLE and set every output to 0 (req_valid, busy, done, src_x_int, src_y_int, frac_x, frac_y, dst_x, dst_y).
REQ-029 rst SHALL clear both accumulators and the latched parameters.
REQ-030 rst mid-frame SHALL abandon the frame with no done pulse; the next start SHALL begin at dst (0,0).

Structure
REQ-031 Package dsa_pkg SHALL hold the state enum coord_state_t, Q16_ONE = 32'h0001_0000, and FRAC_MAX = 16'hFFFF.
REQ-032 Sub-module dsa_axis_stepper SHALL hold the per-axis accumulator, clear, add-step and clamp logic, instantiated once for x and once for y.

Verification
REQ-033 4x4 to 8x8 with step 0x8000 and an ideal fetch model (6 busy cycles): request 0 SHALL be (0,0,0,0); request 1 SHALL be (0,0,0x8000,0); dst_x=6 SHALL be clamped to (2,_,FFFF); the bench SHALL see 64 requests, then a single done pulse.
REQ-034 8x8 to 4x4 with step 0x20000: src_x_int SHALL go 0,2,4,6 per row with frac 0 and no clamp; src_y_int SHALL go 0,2,4,6 across rows.
REQ-035 dst_width=0 with start: done SHALL pulse 2 cycles after start, with zero req_valid pulses.
REQ-036 fetch_busy held at 1 for 10 cycles at frame start: req_valid SHALL stay 0 and SHALL pulse once on the first cycle after fetch_busy falls.
REQ-037 rst pulsed during WAIT_DONE of pixel 5, then start: all outputs SHALL be 0 after rst, there SHALL be no done pulse, and the first new request SHALL be dst (0,0).
REQ-038 start pulsed mid-frame: request sequence and count SHALL be unchanged.
